// File: rtl/piso_serializer_pkg.sv
// rtl/piso_serializer_pkg.sv - shared state type and frame sizing for piso_serializer
// Frame length depends on the PISO_SERIALIZER_PARITY_EN macro.
package piso_serializer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic int frame_of(input int width);
`ifdef PISO_SERIALIZER_PARITY_EN
        return width + 1;
`else
        return width;
`endif
    endfunction

    function automatic int cw_of(input int width);
        return $clog2(frame_of(width) + 1);
    endfunction

endpackage

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in/serial-out transmitter with per-word bit order
// Optional trailing parity bit when PISO_SERIALIZER_PARITY_EN is defined.
module piso_serializer
    import piso_serializer_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       load,
    input  logic [WIDTH-1:0]           data_in,
    input  logic                       msb_first,
    output logic                       ready,
    output logic                       tx,
    output logic                       tx_valid,
    output logic                       fn,
    output logic [cw_of(WIDTH)-1:0]    counter
);

    localparam int FRAME = frame_of(WIDTH);
    localparam int CW    = cw_of(WIDTH);

    state_t           state;
    state_t           state_next;
    logic             accept;
    logic [WIDTH-1:0] ordered;
    logic [FRAME-1:0] word;
    logic [FRAME-1:0] shreg;
    logic [CW-1:0]    cnt;

    // Words are stored pre-ordered so the next bit is always shreg[0].
    always_comb begin
        ordered = '0;
        for (int i = 0; i < WIDTH; i++) begin
            ordered[i] = msb_first ? data_in[WIDTH-1-i] : data_in[i];
        end
    end

`ifdef PISO_SERIALIZER_PARITY_EN
    assign word = {(^data_in) ^ PARITY_ODD, ordered};
`else
    assign word = ordered;
`endif

    always_comb begin
        state_next = state;
        ready      = 1'b0;
        tx_valid   = 1'b0;
        fn         = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (load) begin
                    accept     = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                tx_valid = 1'b1;
                if (cnt == CW'(FRAME)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                ready = 1'b1;
                fn    = 1'b1;
                if (load) begin
                    accept     = 1'b1;
                    state_next = SHIFT;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The register drains to zero by the end of a frame, so tx idles low unaided.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                shreg <= word;
                cnt   <= CW'(1);
            end else if (state == SHIFT) begin
                shreg <= shreg >> 1;
                cnt   <= (cnt == CW'(FRAME)) ? '0 : cnt + CW'(1);
            end
        end
    end

    assign tx      = shreg[0];
    assign counter = cnt;

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - scoreboard bench for piso_serializer
// Parity scenario is built only when PISO_SERIALIZER_PARITY_EN is defined.
module tb_piso_serializer;
    import piso_serializer_pkg::*;

    localparam int WIDTH      = 8;
    localparam bit PARITY_ODD = 1'b0;
`ifdef PISO_SERIALIZER_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif
    localparam int CW = $clog2(FRAME + 1);

    typedef struct packed {
        logic          ready;
        logic          tx;
        logic          tx_valid;
        logic          fn;
        logic [CW-1:0] counter;
    } obs_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             load;
    logic [WIDTH-1:0] data_in;
    logic             msb_first;
    logic             ready;
    logic             tx;
    logic             tx_valid;
    logic             fn;
    logic [CW-1:0]    counter;

    int   total = 0;
    int   bad   = 0;
    obs_t exp_q[$];

    piso_serializer #(.WIDTH(WIDTH), .PARITY_ODD(PARITY_ODD)) dut (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .data_in   (data_in),
        .msb_first (msb_first),
        .ready     (ready),
        .tx        (tx),
        .tx_valid  (tx_valid),
        .fn        (fn),
        .counter   (counter)
    );

    always #5 clk = ~clk;

    function automatic obs_t idle_obs();
        obs_t r;
        r.ready = 1'b1; r.tx = 1'b0; r.tx_valid = 1'b0; r.fn = 1'b0; r.counter = '0;
        return r;
    endfunction

    function automatic string fmt(input obs_t v);
        return $sformatf("rdy=%b tx=%b vld=%b fn=%b cnt=%0d", v.ready, v.tx, v.tx_valid, v.fn, v.counter);
    endfunction

    function automatic obs_t sample();
        obs_t r;
        r.ready = ready; r.tx = tx; r.tx_valid = tx_valid; r.fn = fn; r.counter = counter;
        return r;
    endfunction

    task automatic push_frame(input logic [WIDTH-1:0] d, input logic m);
        obs_t r;
        for (int k = 0; k < WIDTH; k++) begin
            r.ready = 1'b0; r.tx_valid = 1'b1; r.fn = 1'b0;
            r.tx = m ? d[WIDTH-1-k] : d[k];
            r.counter = CW'(k + 1);
            exp_q.push_back(r);
        end
`ifdef PISO_SERIALIZER_PARITY_EN
        r.ready = 1'b0; r.tx_valid = 1'b1; r.fn = 1'b0;
        r.tx = (^d) ^ PARITY_ODD;
        r.counter = CW'(WIDTH + 1);
        exp_q.push_back(r);
`endif
        r.ready = 1'b1; r.tx = 1'b0; r.tx_valid = 1'b0; r.fn = 1'b1; r.counter = '0;
        exp_q.push_back(r);
    endtask

    // Observe the current cycle, drive inputs for the coming edge, advance one cycle.
    task automatic cycle(input logic ld, input logic [WIDTH-1:0] d, input logic m,
                         output obs_t o, output obs_t e);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : idle_obs();
        o = sample();
        load = ld; data_in = d; msb_first = m;
        if (ld && e.ready) push_frame(d, m);
        @(negedge clk);
    endtask

    task automatic test_reset();
        obs_t o, e;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 8'hFF, 1'b0, o, e);
            exp_q.delete();
            total++;
            if (o !== idle_obs()) begin
                bad++;
                $display("FAIL reset_hold[%0d]: got %s want %s", i, fmt(o), fmt(idle_obs()));
            end
        end
        load = 1'b0;
        reset = 1'b1;
        cycle(1'b0, '0, 1'b0, o, e);
        total++;
        if (o !== e) begin
            bad++;
            $display("FAIL reset_release: got %s want %s", fmt(o), fmt(e));
        end
    endtask

    task automatic test_lsb_first();
        obs_t o, e;
        cycle(1'b1, 8'hA5, 1'b0, o, e);
        for (int k = 1; k <= FRAME + 2; k++) begin
            cycle(1'b0, '0, 1'b0, o, e);
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL lsb_a5 cyc%0d: got %s want %s", k, fmt(o), fmt(e));
            end
            if (k == FRAME + 1) begin
                total++;
                if (o.fn !== 1'b1) begin
                    bad++;
                    $display("FAIL lsb_fn_timing: got fn=%b want fn=1", o.fn);
                end
            end
        end
    endtask

    task automatic test_msb_first();
        obs_t o, e;
        logic [WIDTH-1:0] words [2];
        words[0] = 8'hA5;
        words[1] = 8'h01;
        for (int w = 0; w < 2; w++) begin
            cycle(1'b1, words[w], 1'b1, o, e);
            for (int k = 1; k <= FRAME + 1; k++) begin
                cycle(1'b0, '0, 1'b0, o, e);
                total++;
                if (o !== e) begin
                    bad++;
                    $display("FAIL msb_%h cyc%0d: got %s want %s", words[w], k, fmt(o), fmt(e));
                end
            end
        end
    endtask

    task automatic test_busy_load();
        obs_t o, e;
        cycle(1'b1, 8'hFF, 1'b0, o, e);
        for (int k = 1; k <= FRAME + 2; k++) begin
            cycle(k == 3, 8'h00, 1'b1, o, e);
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL busy cyc%0d: got %s want %s", k, fmt(o), fmt(e));
            end
            if (k <= WIDTH) begin
                total++;
                if (o.tx !== 1'b1 || o.ready !== 1'b0) begin
                    bad++;
                    $display("FAIL busy_tx bit%0d: got tx=%b rdy=%b want tx=1 rdy=0", k, o.tx, o.ready);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        obs_t o, e;
        for (int i = 0; i <= 2 * (FRAME + 1) + 2; i++) begin
            cycle(i <= FRAME + 1, (i == 0) ? 8'h0F : 8'hF0, i[0], o, e);
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL b2b cyc%0d: got %s want %s", i, fmt(o), fmt(e));
            end
            if (i == FRAME + 2) begin
                total++;
                if (o.tx_valid !== 1'b1 || o.counter !== CW'(1)) begin
                    bad++;
                    $display("FAIL b2b_gap: got vld=%b cnt=%0d want vld=1 cnt=1", o.tx_valid, o.counter);
                end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        obs_t o, e;
        cycle(1'b1, 8'hA5, 1'b0, o, e);
        for (int k = 1; k <= 3; k++) begin
            cycle(1'b0, '0, 1'b0, o, e);
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL mid_pre cyc%0d: got %s want %s", k, fmt(o), fmt(e));
            end
        end
        total++;
        if (tx_valid !== 1'b1 || counter !== CW'(4)) begin
            bad++;
            $display("FAIL mid_at_bit4: got vld=%b cnt=%0d want vld=1 cnt=4", tx_valid, counter);
        end
        reset = 1'b0;
        #1;
        o = sample();
        exp_q.delete();
        total++;
        if (o !== idle_obs()) begin
            bad++;
            $display("FAIL mid_async_clear: got %s want %s", fmt(o), fmt(idle_obs()));
        end
        for (int k = 0; k < 4; k++) begin
            if (k == 2) reset = 1'b1;
            cycle(1'b0, '0, 1'b0, o, e);
            total++;
            if (o !== e || o.fn !== 1'b0) begin
                bad++;
                $display("FAIL mid_after cyc%0d: got %s want %s", k, fmt(o), fmt(e));
            end
        end
    endtask

    task automatic test_random();
        obs_t o, e;
        for (int i = 0; i < 120 + FRAME + 2; i++) begin
            cycle((i < 120) ? 1'($urandom_range(0, 1)) : 1'b0, WIDTH'($urandom), 1'($urandom_range(0, 1)), o, e);
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL random cyc%0d: got %s want %s", i, fmt(o), fmt(e));
            end
        end
    endtask

`ifdef PISO_SERIALIZER_PARITY_EN
    task automatic test_parity();
        obs_t o, e;
        cycle(1'b1, 8'h07, 1'b0, o, e);
        for (int k = 1; k <= FRAME + 1; k++) begin
            cycle(1'b0, '0, 1'b0, o, e);
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL parity cyc%0d: got %s want %s", k, fmt(o), fmt(e));
            end
            if (k == WIDTH + 1) begin
                total++;
                if (o.tx !== 1'b1 || o.counter !== CW'(9)) begin
                    bad++;
                    $display("FAIL parity_bit: got tx=%b cnt=%0d want tx=1 cnt=9", o.tx, o.counter);
                end
            end
        end
    endtask
`endif

    initial begin
        reset = 1'b0;
        load = 1'b0;
        data_in = '0;
        msb_first = 1'b0;
        @(negedge clk);
        test_reset();
        test_lsb_first();
        test_msb_first();
        test_busy_load();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
`ifdef PISO_SERIALIZER_PARITY_EN
        test_parity();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
